// File: rtl/rib_xbar.sv
// rib_xbar: NUM_MASTERS x NUM_SLAVES RIB interconnect, one transaction in flight, with decode-miss and timeout errors.
// Define RIB_RR_ARB_EN for round-robin arbitration; fixed priority (index 0 highest) otherwise.
module rib_xbar #(
    parameter int          NUM_MASTERS = 4,
    parameter int          NUM_SLAVES  = 8,
    parameter int          SEL_BITS    = 4,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [32*NUM_MASTERS-1:0] m_addr_i,
    input  logic [32*NUM_MASTERS-1:0] m_data_i,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    output logic [32*NUM_MASTERS-1:0] m_data_o,
    output logic [NUM_MASTERS-1:0]    m_ready_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [32*NUM_SLAVES-1:0]  s_addr_o,
    output logic [32*NUM_SLAVES-1:0]  s_data_o,
    input  logic [32*NUM_SLAVES-1:0]  s_data_i,
    output logic [NUM_SLAVES-1:0]     s_we_o,
    output logic [NUM_SLAVES-1:0]     s_req_o,
    input  logic [NUM_SLAVES-1:0]     s_ready_i,
    output logic                      hold_flag_o,
    output logic [NUM_MASTERS-1:0]    grant_o
);
    localparam logic [31:0] SEL_MASK = ~(32'hFFFF_FFFF >> SEL_BITS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q;
    logic [NUM_MASTERS-1:0]  grant_q;
    logic [SEL_BITS-1:0]     sel_q;
    logic [15:0]             cnt_q;

    logic [NUM_MASTERS-1:0]  win_oh;
    logic [SEL_BITS-1:0]     win_sel;
    logic [31:0]             g_addr, g_data, s_rdat;
    logic                    g_we, g_req, s_rdy;
    logic                    busy, miss, tmo, done_ok, done_err, done;

    function automatic logic [NUM_MASTERS-1:0] first_set(input logic [NUM_MASTERS-1:0] v);
        logic [NUM_MASTERS-1:0] oh;
        logic                   found;
        oh    = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (v[k] && !found) begin
                oh[k] = 1'b1;
                found = 1'b1;
            end
        end
        return oh;
    endfunction

`ifdef RIB_RR_ARB_EN
    localparam int PW = $clog2(NUM_MASTERS);
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_MASTERS-1:0] req_hi;

    // Requests at or above the pointer take precedence; wrap to the full set otherwise.
    always_comb begin
        req_hi   = '0;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            req_hi[k] = m_req_i[k] & (PW'(k) >= rr_ptr_q);
        end
        win_oh = (|req_hi) ? first_set(req_hi) : first_set(m_req_i);
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (win_oh[k]) rr_ptr_d = (k == NUM_MASTERS-1) ? '0 : PW'(k+1);
        end
    end
`else
    always_comb win_oh = first_set(m_req_i);
`endif

    always_comb begin
        win_sel = '0;
        g_addr  = '0;
        g_data  = '0;
        g_we    = 1'b0;
        g_req   = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (win_oh[k])  win_sel = win_sel | m_addr_i[32*k+32-SEL_BITS +: SEL_BITS];
            if (grant_q[k]) begin
                g_addr = g_addr | m_addr_i[32*k +: 32];
                g_data = g_data | m_data_i[32*k +: 32];
                g_we   = g_we | m_we_i[k];
                g_req  = g_req | m_req_i[k];
            end
        end
    end

    assign busy = (state_q == BUSY);
    assign miss = ({1'b0, sel_q} >= (SEL_BITS+1)'(NUM_SLAVES));
    assign tmo  = (cnt_q == 16'(TIMEOUT));

    // Slave side: only the decoded slave sees the request, and only while its master still asks.
    always_comb begin
        s_rdy    = 1'b0;
        s_rdat   = '0;
        s_req_o  = '0;
        s_we_o   = '0;
        s_addr_o = '0;
        s_data_o = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (busy && g_req && !miss && sel_q == SEL_BITS'(j)) begin
                s_req_o[j]          = 1'b1;
                s_we_o[j]           = g_we;
                s_addr_o[32*j +: 32] = g_addr & ~SEL_MASK;
                s_data_o[32*j +: 32] = g_data;
                s_rdy               = s_ready_i[j];
                s_rdat              = s_data_i[32*j +: 32];
            end
        end
    end

    // A slave ready in the timeout cycle completes normally.
    assign done_ok  = busy & g_req & ~miss & s_rdy;
    assign done_err = busy & g_req & ~done_ok & (miss | tmo);
    assign done     = done_ok | done_err;

    always_comb begin
        m_ready_o = '0;
        m_err_o   = '0;
        m_data_o  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (done && grant_q[k]) begin
                m_ready_o[k]         = 1'b1;
                m_err_o[k]           = done_err;
                m_data_o[32*k +: 32] = done_err ? ERR_DATA : s_rdat;
            end
        end
    end

    assign hold_flag_o = (busy & ~done) | (~busy & |m_req_i);
    assign grant_o     = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
`ifdef RIB_RR_ARB_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (|m_req_i) begin
                        state_q <= BUSY;
                        grant_q <= win_oh;
                        sel_q   <= win_sel;
`ifdef RIB_RR_ARB_EN
                        rr_ptr_q <= rr_ptr_d;
`endif
                    end
                end
                BUSY: begin
                    if (done || !g_req) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rib_xbar.sv
// Directed bench for rib_xbar: per-cycle vector table plus reset-during-BUSY sequence.
module tb_rib_xbar;
    localparam logic [31:0] ED = 32'hDEAD_BEEF;
`ifdef RIB_RR_ARB_EN
    localparam logic [3:0] SEC = 4'b0100;
`else
    localparam logic [3:0] SEC = 4'b0001;
`endif
    localparam logic [3:0] OTH = 4'b0101 & ~SEC;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] m_addr_i, m_data_i, m_data_o;
    logic [3:0]   m_req_i, m_we_i, m_ready_o, m_err_o, grant_o;
    logic [255:0] s_addr_o, s_data_o, s_data_i;
    logic [7:0]   s_we_o, s_req_o, s_ready_i;
    logic         hold_flag_o;

    int checks = 0;
    int errors = 0;

    rib_xbar #(.NUM_MASTERS(4), .NUM_SLAVES(8), .SEL_BITS(4), .TIMEOUT(4), .ERR_DATA(ED)) dut (
        .clk(clk), .rst(rst),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_req_i(m_req_i), .m_we_i(m_we_i),
        .m_data_o(m_data_o), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_we_o(s_we_o), .s_req_o(s_req_o), .s_ready_i(s_ready_i),
        .hold_flag_o(hold_flag_o), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req, we;
        logic [31:0] a0, a1, a2;
        logic [7:0]  srdy;
        logic [3:0]  e_rdy, e_err;
        logic [7:0]  e_sreq, e_swe;
        logic [3:0]  e_gnt;
        logic        e_hold;
        logic [31:0] e_dat;
    } vec_t;

    localparam int NV = 33;
    vec_t tv[NV];

    function automatic vec_t v(input logic [3:0] req, input logic [3:0] we,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [7:0] srdy, input logic [3:0] er, input logic [3:0] ee,
                               input logic [7:0] es, input logic [7:0] ew, input logic [3:0] eg,
                               input logic eh, input logic [31:0] ed);
        vec_t r;
        r.req = req; r.we = we; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.srdy = srdy;
        r.e_rdy = er; r.e_err = ee; r.e_sreq = es; r.e_swe = ew; r.e_gnt = eg;
        r.e_hold = eh; r.e_dat = ed;
        return r;
    endfunction

    function automatic logic [31:0] sd(input int j);
        return 32'h5A00_0000 + 32'(j);
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] exp_md;

        // m0 write to slave 1, ready on the third BUSY cycle
        tv[0]  = v(4'b0001, 4'b0001, 32'h1000_0004, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 1, 0);
        tv[1]  = v(4'b0001, 4'b0001, 32'h1000_0004, 0, 0, 8'h00, 0, 0, 8'h02, 8'h02, 4'b0001, 1, 0);
        tv[2]  = v(4'b0001, 4'b0001, 32'h1000_0004, 0, 0, 8'h00, 0, 0, 8'h02, 8'h02, 4'b0001, 1, 0);
        tv[3]  = v(4'b0001, 4'b0001, 32'h1000_0004, 0, 0, 8'h02, 4'b0001, 0, 8'h02, 8'h02, 4'b0001, 0, sd(1));
        tv[4]  = v(4'b0000, 4'b0000, 0, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 0);
        // m0 and m2 reads to slave 0, m0 re-requests immediately
        tv[5]  = v(4'b0101, 0, 32'h0000_0010, 0, 32'h0000_0020, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        tv[6]  = v(4'b0101, 0, 32'h0000_0010, 0, 32'h0000_0020, 8'h01, 4'b0001, 0, 8'h01, 0, 4'b0001, 0, sd(0));
        tv[7]  = v(4'b0101, 0, 32'h0000_0010, 0, 32'h0000_0020, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        tv[8]  = v(4'b0101, 0, 32'h0000_0010, 0, 32'h0000_0020, 8'h01, SEC, 0, 8'h01, 0, SEC, 0, sd(0));
        tv[9]  = v(OTH, 0, 32'h0000_0010, 0, 32'h0000_0020, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        tv[10] = v(OTH, 0, 32'h0000_0010, 0, 32'h0000_0020, 8'h01, OTH, 0, 8'h01, 0, OTH, 0, sd(0));
        tv[11] = v(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 0, 0);
        // m1 decode miss
        tv[12] = v(4'b0010, 0, 0, 32'hF000_0000, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        tv[13] = v(4'b0010, 0, 0, 32'hF000_0000, 0, 8'hFF, 4'b0010, 4'b0010, 8'h00, 0, 4'b0010, 0, ED);
        tv[14] = v(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 0, 0);
        // timeout on slave 3
        tv[15] = v(4'b0001, 0, 32'h3000_0000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        for (int i = 16; i <= 19; i++)
            tv[i] = v(4'b0001, 0, 32'h3000_0000, 0, 0, 8'h00, 0, 0, 8'h08, 0, 4'b0001, 1, 0);
        tv[20] = v(4'b0001, 0, 32'h3000_0000, 0, 0, 8'h00, 4'b0001, 4'b0001, 8'h08, 0, 4'b0001, 0, ED);
        tv[21] = v(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 0, 0);
        // ready in the timeout cycle wins
        tv[22] = v(4'b0001, 0, 32'h3000_0000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        for (int i = 23; i <= 26; i++)
            tv[i] = v(4'b0001, 0, 32'h3000_0000, 0, 0, 8'h00, 0, 0, 8'h08, 0, 4'b0001, 1, 0);
        tv[27] = v(4'b0001, 0, 32'h3000_0000, 0, 0, 8'h08, 4'b0001, 0, 8'h08, 0, 4'b0001, 0, sd(3));
        tv[28] = v(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 0, 0);
        // m0 abandons its request mid-transaction
        tv[29] = v(4'b0001, 0, 32'h2000_0000, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 1, 0);
        tv[30] = v(4'b0001, 0, 32'h2000_0000, 0, 0, 8'h00, 0, 0, 8'h04, 0, 4'b0001, 1, 0);
        tv[31] = v(4'b0000, 0, 32'h2000_0000, 0, 0, 8'h04, 0, 0, 8'h00, 0, 4'b0001, 1, 0);
        tv[32] = v(4'b0000, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 0, 0);

        rst = 1'b1;
        m_req_i = '0; m_we_i = '0; m_addr_i = '0; s_ready_i = '0;
        m_data_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA5A5_5A5A};
        for (int j = 0; j < 8; j++) s_data_i[32*j +: 32] = sd(j);

        step();
        step();
        chk("rst ready", m_ready_o, 0);
        chk("rst err", m_err_o, 0);
        chk("rst sreq", s_req_o, 0);
        chk("rst swe", s_we_o, 0);
        chk("rst grant", grant_o, 0);
        chk("rst hold", hold_flag_o, 0);
        chk("rst mdata", m_data_o, 0);
        chk("rst saddr", s_addr_o, 0);
        chk("rst sdata", s_data_o, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            m_req_i   = tv[i].req;
            m_we_i    = tv[i].we;
            m_addr_i  = {32'h0, tv[i].a2, tv[i].a1, tv[i].a0};
            s_ready_i = tv[i].srdy;
            #1;
            exp_md = '0;
            for (int k = 0; k < 4; k++) if (tv[i].e_rdy[k]) exp_md[32*k +: 32] = tv[i].e_dat;
            chk($sformatf("row%0d ready", i), m_ready_o, tv[i].e_rdy);
            chk($sformatf("row%0d err", i), m_err_o, tv[i].e_err);
            chk($sformatf("row%0d sreq", i), s_req_o, tv[i].e_sreq);
            chk($sformatf("row%0d swe", i), s_we_o, tv[i].e_swe);
            chk($sformatf("row%0d grant", i), grant_o, tv[i].e_gnt);
            chk($sformatf("row%0d hold", i), hold_flag_o, tv[i].e_hold);
            chk($sformatf("row%0d mdata", i), m_data_o, exp_md);
            if (i == 1) begin
                chk("wr saddr", s_addr_o[32 +: 32], 32'h0000_0004);
                chk("wr sdata", s_data_o[32 +: 32], 32'hA5A5_5A5A);
            end
            step();
        end

        // reset while m2 write to slave 5 is in BUSY
        m_req_i = 4'b0100; m_we_i = 4'b0100; m_addr_i = {32'h0, 32'h5000_0008, 64'h0}; s_ready_i = '0;
        step();
        chk("busy grant", grant_o, 4'b0100);
        chk("busy sreq", s_req_o, 8'h20);
        chk("busy saddr", s_addr_o[160 +: 32], 32'h0000_0008);
        chk("busy sdata", s_data_o[160 +: 32], 32'h2222_2222);
        rst = 1'b1;
        step();
        chk("mid rst grant", grant_o, 0);
        chk("mid rst sreq", s_req_o, 0);
        chk("mid rst swe", s_we_o, 0);
        chk("mid rst ready", m_ready_o, 0);
        chk("mid rst saddr", s_addr_o, 0);
        step();
        chk("held rst grant", grant_o, 0);
        rst = 1'b0;
        step();
        chk("reissue grant", grant_o, 4'b0100);
        chk("reissue swe", s_we_o, 8'h20);
        s_ready_i = 8'h20;
        #1;
        chk("reissue ready", m_ready_o, 4'b0100);
        chk("reissue err", m_err_o, 0);
        chk("reissue mdata", m_data_o, {32'h0, sd(5), 64'h0});
        step();
        m_req_i = '0; m_we_i = '0; s_ready_i = '0;
        #1;
        chk("after grant", grant_o, 0);
        chk("after hold", hold_flag_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
